risc_v_trace_buffer: RTL and testbench
======================================

// Module: risc_v_trace_buffer
// PURPOSE
//  On-chip probe capture for the RISC_V_UNDER_TOP core: records CH probe words per EN cycle
//  (e.g. PC, INST_DATA, ALU_RES, RESULT_DATA) into a circular buffer of DEPTH entries.
//  Stops POST_TRIG samples after a trigger, then streams the buffer out oldest-first over valid/ready.
//  Sits beside the core; lets FPGA runs reproduce what the simulation bench watches on waveforms.
// PARAMETERS
//  DATA_W    32  width of one probe channel
//  CH        4   number of probe channels; sample width SW_W = CH*DATA_W
//  DEPTH     16  buffer entries; power of 2, >= 2; AW = $clog2(DEPTH)
//  POST_TRIG 8   samples captured after the trigger sample; 0 <= POST_TRIG < DEPTH
// PORTS
//  CLK       in   1        clock, rising edge
//  RST       in   1        reset, asynchronous, active-high
//  CLR       in   1        synchronous abort to IDLE, highest priority after RST
//  ARM       in   1        start capture; honoured only in IDLE
//  EN        in   1        sample strobe; PROBE written only when EN=1
//  TRIG_IN   in   1        trigger; qualified by EN, honoured only in ARMED
//  PROBE     in   SW_W     {ch[CH-1],...,ch[0]} sample data
//  RD_VALID  out  1        readout word valid
//  RD_READY  in   1        readout consumer ready
//  RD_DATA   out  SW_W     readout sample
//  RD_LAST   out  1        high with the final readout word
//  STATE     out  2        0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  COUNT     out  AW+1     valid samples held (saturates at DEPTH)
//  TRIG_IDX  out  AW       readout position of the trigger sample, valid in DONE
// BEHAVIOUR
//  Reset: STATE=IDLE, wr_ptr=0, rd_ptr=0, COUNT=0, TRIG_IDX=0, RD_VALID=0, RD_LAST=0; RD_DATA don't-care
//   (storage not cleared). RST mid-capture/readout aborts at once; no partial readout afterwards.
//  IDLE: ARM=1 -> ARMED next edge; wr_ptr<=0, COUNT<=0. EN/TRIG_IN ignored.
//  ARMED: each edge with EN=1: mem[wr_ptr]<=PROBE, wr_ptr<=wr_ptr+1 (mod DEPTH), COUNT<=min(COUNT+1,DEPTH).
//   EN=1&TRIG_IN=1: that sample is written (trigger sample); post<=POST_TRIG;
//   -> POST, or -> DONE directly if POST_TRIG=0. TRIG_IN with EN=0 ignored.
//  POST: each EN=1 edge writes as above, post<=post-1; the edge writing the last post sample
//   (post==1) -> DONE. TRIG_IN ignored. EN=0 cycles: no write, no count.
//  DONE entry: rd_ptr <= (COUNT==DEPTH) ? wr_ptr : 0 (oldest sample); remaining <= COUNT;
//   TRIG_IDX <= COUNT-1-POST_TRIG (computed from the final COUNT, including the last write).
//  DONE: RD_VALID=1 while remaining>0; RD_DATA=mem[rd_ptr] (combinational read);
//   RD_LAST=RD_VALID&(remaining==1). On RD_VALID&RD_READY: rd_ptr++ (mod DEPTH), remaining--;
//   transfer with RD_LAST -> IDLE next edge (RD_VALID low next cycle). While RD_VALID&!RD_READY,
//   RD_DATA/RD_LAST held stable. EN, TRIG_IN, ARM ignored in DONE (no writes to storage).
//  CLR=1 in any state -> IDLE next edge, RD_VALID<=0; beats ARM if simultaneous.
//  Capture latency: PROBE sampled on the edge where EN=1; first readout word valid the cycle after DONE entry.
//  Arithmetic: pointers wrap naturally at AW bits; COUNT saturating compare, never wraps.
// STRUCTURE
//  Shared include risc_v_defs.vh: state encodings TB_IDLE/TB_ARMED/TB_POST/TB_DONE.
//  Sub-module trace_ram: DEPTH x SW_W, 1 sync write port, 1 async read port, no reset.
//  Top holds FSM, wr/rd pointers, COUNT, post and remaining counters, TRIG_IDX register.
// TESTING  (bench params DATA_W=8, CH=2, DEPTH=8, POST_TRIG=3; PROBE={~n,n} for sample n)
//  1 Wrap: ARM, EN=1 every cycle, TRIG_IN at n=10 -> DONE after n=13, COUNT=8, readout n=6..13
//    in order, TRIG_IDX=4, RD_LAST only with n=13, then STATE=IDLE.
//  2 No wrap: trigger at n=2 -> COUNT=6, readout n=0..5, TRIG_IDX=2.
//  3 EN gaps: EN toggles 1/0, TRIG_IN pulsed on an EN=0 cycle -> no trigger; later trigger with EN=1
//    -> only EN=1 samples appear in readout, no duplicates.
//  4 Backpressure: RD_READY random 50% -> every word delivered once, RD_DATA stable while stalled.
//  5 Abort: RST asserted in POST -> all outputs at reset values immediately; CLR mid-readout ->
//    IDLE next edge, RD_VALID=0; re-ARM then capture of test 1 repeats identically.
//  6 Edges: POST_TRIG=0 build, trigger at n=5 -> DONE same edge, readout n=0..5, TRIG_IDX=5;
//    TRIG_IN held high through POST -> single trigger only.

Source files
------------

// File: rtl/risc_v_trace_buffer_pkg.sv
// Shared types for the RISC-V probe trace buffer: capture FSM state encodings.
package risc_v_trace_buffer_pkg;

  typedef enum logic [1:0] {
    TB_IDLE  = 2'd0,
    TB_ARMED = 2'd1,
    TB_POST  = 2'd2,
    TB_DONE  = 2'd3
  } tb_state_e;

endpackage

// File: rtl/risc_v_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x W, one synchronous write port, one asynchronous read port, no reset.
module risc_v_trace_buffer_trace_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/risc_v_trace_buffer.sv
// Probe trace buffer: circular capture of CH probe words, stops POST_TRIG samples after a
// trigger, then streams the buffer out oldest-first over valid/ready.
//  state    | meaning
//  TB_IDLE  | waiting for arm, storage untouched
//  TB_ARMED | writing every en sample, waiting for a qualified trigger
//  TB_POST  | writing the post-trigger samples
//  TB_DONE  | streaming the captured samples out
module risc_v_trace_buffer
  import risc_v_trace_buffer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CH        = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  localparam int SW_W     = CH * DATA_W,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            arm,
  input  logic            en,
  input  logic            trig_in,
  input  logic [SW_W-1:0] probe,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [SW_W-1:0] rd_data,
  output logic            rd_last,
  output logic [1:0]      state,
  output logic [AW:0]     count,
  output logic [AW-1:0]   trig_idx
);

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   TRIG_OFS  = (AW+1)'(POST_TRIG + 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  tb_state_e     state_q;
  logic [AW-1:0] wr_ptr, rd_ptr, post_q, trig_idx_q, wr_ptr_inc;
  logic [AW:0]   count_q, remaining, count_inc;
  logic          we, done_hit;

  assign we         = (state_q == TB_ARMED || state_q == TB_POST) && en && !clr;
  assign wr_ptr_inc = wr_ptr + PTR_ONE;
  assign count_inc  = (count_q == DEPTH_C) ? count_q : count_q + CNT_ONE;
  // The write that completes the capture: trigger itself when there is no post window.
  assign done_hit   = (state_q == TB_ARMED && trig_in && POST_TRIG == 0) ||
                      (state_q == TB_POST && post_q == PTR_ONE);

  assign rd_valid = (state_q == TB_DONE) && (remaining != '0);
  assign rd_last  = rd_valid && (remaining == CNT_ONE);
  assign state    = state_q;
  assign count    = count_q;
  assign trig_idx = trig_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TB_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      post_q     <= '0;
      remaining  <= '0;
      trig_idx_q <= '0;
    end else if (clr) begin
      state_q   <= TB_IDLE;
      remaining <= '0;
    end else begin
      case (state_q)
        TB_IDLE: begin
          if (arm) begin
            state_q <= TB_ARMED;
            wr_ptr  <= '0;
            count_q <= '0;
          end
        end
        TB_ARMED, TB_POST: begin
          if (en) begin
            wr_ptr  <= wr_ptr_inc;
            count_q <= count_inc;
            if (done_hit) begin
              state_q    <= TB_DONE;
              rd_ptr     <= (count_inc == DEPTH_C) ? wr_ptr_inc : '0;
              remaining  <= count_inc;
              trig_idx_q <= AW'(count_inc - TRIG_OFS);
            end else if (state_q == TB_ARMED && trig_in) begin
              state_q <= TB_POST;
              post_q  <= POST_INIT;
            end else if (state_q == TB_POST) begin
              post_q <= post_q - PTR_ONE;
            end
          end
        end
        TB_DONE: begin
          if (rd_valid && rd_ready) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            remaining <= remaining - CNT_ONE;
            if (rd_last) state_q <= TB_IDLE;
          end
        end
        default: state_q <= TB_IDLE;
      endcase
    end
  end

  risc_v_trace_buffer_trace_ram #(
    .W     (SW_W),
    .DEPTH (DEPTH)
  ) u_trace_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (probe),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_risc_v_trace_buffer.sv
// Scoreboard bench for risc_v_trace_buffer: POST_TRIG=3 instance (a) and POST_TRIG=0 instance (b).
module tb_risc_v_trace_buffer;

  localparam int SW = 16;
  localparam int AWL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, arm, en, trig, rd_ready;
  logic [SW-1:0] probe, rd_data;
  logic rd_valid, rd_last;
  logic [1:0] state;
  logic [AWL:0] count;
  logic [AWL-1:0] trig_idx;

  logic clr_b, arm_b, en_b, trig_b, rd_ready_b;
  logic [SW-1:0] probe_b, rd_data_b;
  logic rd_valid_b, rd_last_b;
  logic [1:0] state_b;
  logic [AWL:0] count_b;
  logic [AWL-1:0] trig_idx_b;

  risc_v_trace_buffer #(.DATA_W(8), .CH(2), .DEPTH(8), .POST_TRIG(3)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .arm(arm), .en(en), .trig_in(trig), .probe(probe),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .state(state), .count(count), .trig_idx(trig_idx)
  );

  risc_v_trace_buffer #(.DATA_W(8), .CH(2), .DEPTH(8), .POST_TRIG(0)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .arm(arm_b), .en(en_b), .trig_in(trig_b), .probe(probe_b),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready_b), .rd_data(rd_data_b), .rd_last(rd_last_b),
    .state(state_b), .count(count_b), .trig_idx(trig_idx_b)
  );

  int tests = 0;
  int fails = 0;
  logic [SW:0] exp_a[$];
  logic [SW:0] exp_b[$];
  logic stall[2] = '{1'b0, 1'b0};
  logic [SW:0] held[2];

  function automatic logic [SW-1:0] pat(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {~b, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor: one word {last,data} per handshake, plus stability of a stalled word.
  task automatic mon(input int i, input logic v, input logic r, input logic l,
                     input logic [SW-1:0] d, input logic c);
    logic [SW:0] got, want;
    got = {l, d};
    if (stall[i] && !rst && !c) begin
      tests++;
      if (v !== 1'b1 || got !== held[i]) begin
        fails++;
        $display("FAIL stall%0d: got valid=%0b word=%h required valid=1 word=%h", i, v, got, held[i]);
      end
    end
    if (v && r) begin
      tests++;
      if ((i == 0 ? exp_a.size() : exp_b.size()) == 0) begin
        fails++;
        $display("FAIL beat%0d: got unexpected word %h required none", i, got);
      end else begin
        want = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL beat%0d: got word %h required %h", i, got, want);
        end
      end
    end
    stall[i] = v && !r && !rst && !c;
    held[i]  = got;
  endtask

  always @(negedge clk) begin
    mon(0, rd_valid, rd_ready, rd_last, rd_data, clr);
    mon(1, rd_valid_b, rd_ready_b, rd_last_b, rd_data_b, clr_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int i, input bit e, input bit t, input int n);
    if (i == 0) begin
      en = e; trig = t; probe = e ? pat(n) : 16'hA5A5;
    end else begin
      en_b = e; trig_b = t; probe_b = e ? pat(n) : 16'hA5A5;
    end
    tick();
  endtask

  task automatic do_arm(input int i);
    if (i == 0) arm = 1'b1; else arm_b = 1'b1;
    tick();
    arm = 1'b0; arm_b = 1'b0;
    chk($sformatf("armed%0d", i), (i == 0) ? 32'(state) : 32'(state_b), 1);
  endtask

  task automatic capture(input int i, input int lo, input int hi, input int tn, input bit hold);
    do_arm(i);
    for (int n = lo; n <= hi; n++) step(i, 1'b1, hold ? (n >= tn) : (n == tn), n);
    en = 1'b0; trig = 1'b0; en_b = 1'b0; trig_b = 1'b0;
  endtask

  task automatic push(input int i, input int lo, input int hi);
    for (int n = lo; n <= hi; n++) begin
      if (i == 0) exp_a.push_back({n == hi, pat(n)});
      else        exp_b.push_back({n == hi, pat(n)});
    end
  endtask

  task automatic drain(input int i, input bit rnd, input int max_cyc);
    int cyc;
    cyc = 0;
    while ((i == 0 ? exp_a.size() : exp_b.size()) != 0 && cyc < max_cyc) begin
      if (i == 0) rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      else        rd_ready_b = 1'b1;
      tick();
      cyc++;
    end
    rd_ready = 1'b0; rd_ready_b = 1'b0;
    chk($sformatf("drain_left%0d", i), (i == 0) ? exp_a.size() : exp_b.size(), 0);
    chk($sformatf("idle_after%0d", i), (i == 0) ? 32'(state) : 32'(state_b), 0);
    chk($sformatf("valid_after%0d", i), (i == 0) ? 32'(rd_valid) : 32'(rd_valid_b), 0);
  endtask

  task automatic test1_capture();
    capture(0, 0, 13, 10, 1'b0);
    chk("t1_state", 32'(state), 3);
    chk("t1_count", 32'(count), 8);
    chk("t1_trig_idx", 32'(trig_idx), 4);
    push(0, 6, 13);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = 1'b0; arm = 1'b0; en = 1'b0; trig = 1'b0; rd_ready = 1'b0; probe = '0;
    clr_b = 1'b0; arm_b = 1'b0; en_b = 1'b0; trig_b = 1'b0; rd_ready_b = 1'b0; probe_b = '0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_trig_idx", 32'(trig_idx), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_last", 32'(rd_last), 0);
    rst = 1'b0;
    tick();

    // 1: wrap
    test1_capture();
    drain(0, 1'b0, 40);

    // 2: no wrap
    capture(0, 0, 5, 2, 1'b0);
    chk("t2_state", 32'(state), 3);
    chk("t2_count", 32'(count), 6);
    chk("t2_trig_idx", 32'(trig_idx), 2);
    push(0, 0, 5);
    drain(0, 1'b0, 40);

    // 3: en gaps, trigger on an en=0 cycle ignored
    do_arm(0);
    step(0, 1'b1, 1'b0, 0);
    step(0, 1'b0, 1'b1, 0);
    chk("t3_no_trig", 32'(state), 1);
    step(0, 1'b1, 1'b0, 1);
    step(0, 1'b0, 1'b0, 0);
    step(0, 1'b1, 1'b1, 2);
    chk("t3_post", 32'(state), 2);
    step(0, 1'b0, 1'b0, 0);
    step(0, 1'b1, 1'b0, 3);
    step(0, 1'b0, 1'b1, 0);
    step(0, 1'b1, 1'b0, 4);
    step(0, 1'b0, 1'b0, 0);
    chk("t3_still_post", 32'(state), 2);
    step(0, 1'b1, 1'b0, 5);
    en = 1'b0; trig = 1'b0;
    chk("t3_state", 32'(state), 3);
    chk("t3_count", 32'(count), 6);
    chk("t3_trig_idx", 32'(trig_idx), 2);
    push(0, 0, 5);
    drain(0, 1'b0, 40);

    // 4: random backpressure
    capture(0, 20, 33, 30, 1'b0);
    chk("t4_count", 32'(count), 8);
    chk("t4_trig_idx", 32'(trig_idx), 4);
    push(0, 26, 33);
    drain(0, 1'b1, 200);

    // 5a: reset during POST
    do_arm(0);
    for (int n = 0; n <= 11; n++) step(0, 1'b1, n == 10, n);
    en = 1'b0; trig = 1'b0;
    chk("t5_post", 32'(state), 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_state", 32'(state), 0);
    chk("t5_rst_count", 32'(count), 0);
    chk("t5_rst_trig_idx", 32'(trig_idx), 0);
    chk("t5_rst_valid", 32'(rd_valid), 0);
    chk("t5_rst_last", 32'(rd_last), 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t5_no_readout", 32'(rd_valid), 0);
    chk("t5_idle", 32'(state), 0);

    // 5b: clr mid-readout beats a simultaneous arm, then the wrap capture repeats
    test1_capture();
    exp_a.delete();
    push(0, 6, 8);
    exp_a[2][SW] = 1'b0;
    rd_ready = 1'b1;
    tick(); tick(); tick();
    chk("t5_partial_left", exp_a.size(), 0);
    rd_ready = 1'b0; clr = 1'b1; arm = 1'b1;
    tick();
    clr = 1'b0; arm = 1'b0;
    chk("t5_clr_state", 32'(state), 0);
    chk("t5_clr_valid", 32'(rd_valid), 0);
    tick();
    chk("t5_clr_stays_idle", 32'(state), 0);
    test1_capture();
    drain(0, 1'b0, 40);

    // 6a: trigger held high through POST gives a single trigger
    capture(0, 0, 5, 2, 1'b1);
    chk("t6_hold_state", 32'(state), 3);
    chk("t6_hold_count", 32'(count), 6);
    chk("t6_hold_trig_idx", 32'(trig_idx), 2);
    push(0, 0, 5);
    drain(0, 1'b0, 40);

    // 6b: POST_TRIG=0 build, done on the trigger edge
    do_arm(1);
    for (int n = 0; n <= 4; n++) step(1, 1'b1, 1'b0, n);
    chk("t6_b_armed", 32'(state_b), 1);
    step(1, 1'b1, 1'b1, 5);
    en_b = 1'b0; trig_b = 1'b0;
    chk("t6_b_state", 32'(state_b), 3);
    chk("t6_b_count", 32'(count_b), 6);
    chk("t6_b_trig_idx", 32'(trig_idx_b), 5);
    push(1, 0, 5);
    drain(1, 1'b0, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
